// File: rtl/mem_access.sv
// MIPS memory-access stage: loads/stores over a req/ack data bus, with bus-timeout detection.
// Optional POSTED_STORE_EN macro: aligned stores retire at once and drain from a one-entry buffer.
module mem_access #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic        OutValid,
  output logic [31:0] WBdata,
  output logic        AdrErr,
  output logic        BusErr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSw  = 6'h2B;

  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

  if (TIMEOUT < 2 || TIMEOUT > 65536 || (TO_W < 32 && (64'(1) << TO_W) < 64'(TIMEOUT)))
  begin : g_param_check
    $error("mem_access: TIMEOUT out of range or TO_W too narrow");
  end

  // Registered state
  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            outvalid_q, outvalid_d;
  logic [31:0]     wbdata_q, wbdata_d;
  logic            adrerr_q, adrerr_d;
  logic            buserr_q, buserr_d;
  logic [TO_W-1:0] to_q, to_d;
`ifdef POSTED_STORE_EN
  logic            sb_q, sb_d;
`endif

  // Instruction decode
  logic [5:0]  op;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misaligned;
  logic        timeout_hit;
  logic        issue;
  logic        stall;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic        unused_ins;

  assign op          = Ins[31:26];
  assign unused_ins  = ^Ins[25:0];
  assign timeout_hit = (to_q == ToLast);

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (op)
      OpLb, OpLh, OpLw, OpLbu, OpLhu: is_load  = 1'b1;
      OpSb, OpSh, OpSw:               is_store = 1'b1;
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OpLh, OpLhu, OpSh: misaligned = Result[0];
      OpLw, OpSw:        misaligned = (Result[1:0] != 2'b00);
      default: ;
    endcase
  end

  // Store lane steering; loads keep all lanes enabled
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = Rdata2;
    case (op)
      OpSb: begin
        st_be    = 4'b0001 << Result[1:0];
        st_wdata = {4{Rdata2[7:0]}};
      end
      OpSh: begin
        st_be    = Result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{Rdata2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction; Ins/Result are held stable by Stall while BUSY
  always_comb begin
    unique case (Result[1:0])
      2'd0: rd_byte = dmem_rdata[7:0];
      2'd1: rd_byte = dmem_rdata[15:8];
      2'd2: rd_byte = dmem_rdata[23:16];
      2'd3: rd_byte = dmem_rdata[31:24];
    endcase
    rd_half = Result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op)
      OpLb:    load_val = {{24{rd_byte[7]}}, rd_byte};
      OpLbu:   load_val = {24'h0, rd_byte};
      OpLh:    load_val = {{16{rd_half[15]}}, rd_half};
      OpLhu:   load_val = {16'h0, rd_half};
      OpLw:    load_val = dmem_rdata;
      default: load_val = '0;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    outvalid_d = 1'b0;
    wbdata_d   = wbdata_q;
    adrerr_d   = 1'b0;
    buserr_d   = 1'b0;
    to_d       = to_q;
    issue      = 1'b0;
    stall      = 1'b0;
`ifdef POSTED_STORE_EN
    sb_d       = sb_q;

    // Posted store drains independently of the pipeline FSM
    if (sb_q) begin
      if (dmem_ack) begin
        req_d = 1'b0;
        sb_d  = 1'b0;
        to_d  = '0;
      end else if (timeout_hit) begin
        req_d    = 1'b0;
        sb_d     = 1'b0;
        to_d     = '0;
        buserr_d = 1'b1;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
`endif

    case (state_q)
      StIdle: begin
        if (Valid) begin
          if (!is_mem) begin
            outvalid_d = 1'b1;
            wbdata_d   = Result;
          end
`ifdef POSTED_STORE_EN
          else if (sb_q) begin
            stall = 1'b1;
          end
`endif
          else if (misaligned) begin
            outvalid_d = 1'b1;
            adrerr_d   = 1'b1;
            wbdata_d   = '0;
          end
`ifdef POSTED_STORE_EN
          else if (is_store) begin
            issue      = 1'b1;
            sb_d       = 1'b1;
            outvalid_d = 1'b1;
            wbdata_d   = '0;
          end
`endif
          else begin
            issue   = 1'b1;
            stall   = 1'b1;
            state_d = StBusy;
          end
        end
      end

      StBusy: begin
        stall = 1'b1;
        if (dmem_ack) begin
          req_d      = 1'b0;
          to_d       = '0;
          state_d    = StDone;
          outvalid_d = 1'b1;
          wbdata_d   = is_load ? load_val : '0;
        end else if (timeout_hit) begin
          req_d      = 1'b0;
          to_d       = '0;
          state_d    = StDone;
          outvalid_d = 1'b1;
          buserr_d   = 1'b1;
          wbdata_d   = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      StDone: begin
        // OutValid is high this cycle; the completed instruction is still on the inputs
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    if (issue) begin
      req_d   = 1'b1;
      we_d    = is_store;
      addr_d  = {Result[31:2], 2'b00};
      be_d    = st_be;
      wdata_d = st_wdata;
      to_d    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      outvalid_q <= 1'b0;
      wbdata_q   <= '0;
      adrerr_q   <= 1'b0;
      buserr_q   <= 1'b0;
      to_q       <= '0;
`ifdef POSTED_STORE_EN
      sb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      outvalid_q <= outvalid_d;
      wbdata_q   <= wbdata_d;
      adrerr_q   <= adrerr_d;
      buserr_q   <= buserr_d;
      to_q       <= to_d;
`ifdef POSTED_STORE_EN
      sb_q       <= sb_d;
`endif
    end
  end

  assign Stall      = stall;
  assign OutValid   = outvalid_q;
  assign WBdata     = wbdata_q;
  assign AdrErr     = adrerr_q;
  assign BusErr     = buserr_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table, scoreboard queue, bus responder model.
module tb_mem_access;

  localparam int unsigned TO = 4;

  logic        CLK;
  logic        RST;
  logic        Valid;
  logic [31:0] Ins;
  logic [31:0] Result;
  logic [31:0] Rdata2;
  logic        Stall;
  logic        OutValid;
  logic [31:0] WBdata;
  logic        AdrErr;
  logic        BusErr;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  mem_access #(
    .TIMEOUT(TO),
    .TO_W   (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Valid     (Valid),
    .Ins       (Ins),
    .Result    (Result),
    .Rdata2    (Rdata2),
    .Stall     (Stall),
    .OutValid  (OutValid),
    .WBdata    (WBdata),
    .AdrErr    (AdrErr),
    .BusErr    (BusErr),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_be   (dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_ack  (dmem_ack),
    .dmem_rdata(dmem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] res;
    logic [31:0] rd2;
    logic [31:0] rdat;
    int          dly;    // ack in req cycle dly (0 = first); -1 = never
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
    logic        adr;
    logic        berr;
    int          stall;
  } vec_t;

  typedef struct packed {
    logic [31:0] wb;
    logic        adr;
    logic        berr;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          req_cnt = 0;
  int          req_starts = 0;
  int          last_req_len = 0;
  int          resp_delay = -1;
  logic [31:0] resp_data = '0;
  logic        ack_r = 1'b0;
  logic        chk_bus = 1'b0;
  logic        e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: wait for the falling edge, run the output monitor and the bus responder
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    if (!RST) begin
      if (OutValid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_outvalid", 32'(OutValid), 32'(0));
        end else begin
          e = sbq.pop_front();
          chk("wbdata", WBdata, e.wb);
          chk("adrerr", 32'(AdrErr), 32'(e.adr));
          chk("buserr", 32'(BusErr), 32'(e.berr));
        end
      end else if (AdrErr || BusErr) begin
        chk("err_without_outvalid", 32'({AdrErr, BusErr}), 32'(0));
      end
    end
    if (RST || !dmem_req) begin
      if (req_cnt > 0) last_req_len = req_cnt;
      req_cnt = 0;
      ack_r   = 1'b0;
    end else begin
      if (req_cnt == 0) begin
        req_starts++;
        if (chk_bus) begin
          chk("dmem_addr", dmem_addr, e_addr);
          chk("dmem_we", 32'(dmem_we), 32'(e_we));
          chk("dmem_be", 32'(dmem_be), 32'(e_be));
          if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
        end
      end
      ack_r = (resp_delay >= 0) && (req_cnt == resp_delay);
      req_cnt++;
    end
    dmem_ack   = ack_r;
    dmem_rdata = ack_r ? resp_data : 32'hDEAD_BEEF;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int starts0;
    int sc;
    bit ok;
    starts0    = req_starts;
    e_we       = v.we;
    e_be       = v.be;
    e_addr     = v.addr;
    e_wdata    = v.wdata;
    chk_bus    = 1'b1;
    resp_delay = v.dly;
    resp_data  = v.rdat;
    sbq.push_back('{wb: v.wb, adr: v.adr, berr: v.berr});
    Valid  = 1'b1;
    Ins    = {v.op, 26'h0};
    Result = v.res;
    Rdata2 = v.rd2;
    sc = 0;
    ok = 1'b0;
    #1;
    for (int n = 0; n < 64; n++) begin
      if (!Stall) begin
        ok = 1'b1;
        break;
      end
      sc++;
      tick();
      #1;
    end
    chk($sformatf("v%0d_accepted", idx), 32'(ok), 32'(1));
    chk($sformatf("v%0d_stall_cycles", idx), 32'(sc), 32'(v.stall));
    tick();
    Valid = 1'b0;
    Ins   = '0;
    tick();
    tick();
    chk($sformatf("v%0d_pending_results", idx), 32'(sbq.size()), 32'(0));
    sbq.delete();
    chk($sformatf("v%0d_req_count", idx), 32'(req_starts - starts0), 32'(v.req ? 1 : 0));
    if (v.berr) chk($sformatf("v%0d_req_cycles", idx), 32'(last_req_len), 32'(TO));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[19];
    vec_t v;
    int   ov_seen;
    bit   seen;

    //               op     res           rd2           rdat          dly req we addr          be       wdata         wb            adr berr stall
    vecs[0]  = '{6'h00, 32'h1234_5678, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h1234_5678, 0, 0, 0};
    vecs[1]  = '{6'h20, 32'h0000_0103, 32'h0,        32'h80FF_0011, 0, 1, 0, 32'h100,      4'hF, 32'h0,        32'hFFFF_FF80, 0, 0, 2};
    vecs[2]  = '{6'h29, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        3, 1, 1, 32'h200,      4'hC, 32'hBEEF_BEEF, 32'h0,        0, 0, 5};
    vecs[3]  = '{6'h23, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 0};
    vecs[4]  = '{6'h24, 32'h0000_0101, 32'h0,        32'h1234_F0AB, 1, 1, 0, 32'h100,      4'hF, 32'h0,        32'h0000_00F0, 0, 0, 3};
    vecs[5]  = '{6'h21, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 0, 1, 0, 32'h100,      4'hF, 32'h0,        32'hFFFF_8001, 0, 0, 2};
    vecs[6]  = '{6'h25, 32'h0000_0100, 32'h0,        32'h8001_F00F, 2, 1, 0, 32'h100,      4'hF, 32'h0,        32'h0000_F00F, 0, 0, 4};
    vecs[7]  = '{6'h23, 32'h0000_0010, 32'h0,        32'hCAFE_F00D, 2, 1, 0, 32'h10,       4'hF, 32'h0,        32'hCAFE_F00D, 0, 0, 4};
    vecs[8]  = '{6'h28, 32'h0000_0301, 32'h1234_56A5, 32'h0,        0, 1, 1, 32'h300,      4'h2, 32'hA5A5_A5A5, 32'h0,        0, 0, 2};
    vecs[9]  = '{6'h2B, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0,        1, 1, 1, 32'h400,      4'hF, 32'hDEAD_BEEF, 32'h0,        0, 0, 3};
    vecs[10] = '{6'h21, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 0};
    vecs[11] = '{6'h29, 32'h0000_0203, 32'h0000_1111, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 0};
    vecs[12] = '{6'h2B, 32'h0000_0402, 32'h0000_2222, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 0};
    vecs[13] = '{6'h20, 32'h0000_0007, 32'h0,        32'h7F00_0000, 0, 1, 0, 32'h4,        4'hF, 32'h0,        32'h0000_007F, 0, 0, 2};
    vecs[14] = '{6'h08, 32'hFFFF_0000, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'hFFFF_0000, 0, 0, 0};
    vecs[15] = '{6'h23, 32'h0000_0020, 32'h0,        32'h0,       -1, 1, 0, 32'h20,       4'hF, 32'h0,        32'h0,        0, 1, 5};
    vecs[16] = '{6'h25, 32'h0000_0103, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 0};
    vecs[17] = '{6'h28, 32'h0000_0002, 32'h0000_00C3, 32'h0,        0, 1, 1, 32'h0,        4'h4, 32'hC3C3_C3C3, 32'h0,        0, 0, 2};
    vecs[18] = '{6'h00, 32'hA5A5_0F0F, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'hA5A5_0F0F, 0, 0, 0};

    RST        = 1'b1;
    Valid      = 1'b0;
    Ins        = '0;
    Result     = '0;
    Rdata2     = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    repeat (3) tick();

    chk("rst_stall", 32'(Stall), 32'(0));
    chk("rst_outvalid", 32'(OutValid), 32'(0));
    chk("rst_wbdata", WBdata, 32'h0);
    chk("rst_errs", 32'({AdrErr, BusErr}), 32'(0));
    chk("rst_req_we", 32'({dmem_req, dmem_we}), 32'(0));
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", 32'(dmem_be), 32'(0));
    chk("rst_wdata", dmem_wdata, 32'h0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

    // Valid low in IDLE: no pulse, write-back value holds
    ov_seen = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (OutValid) ov_seen++;
    end
    chk("idle_no_outvalid", 32'(ov_seen), 32'(0));
    chk("idle_wbdata_holds", WBdata, 32'hA5A5_0F0F);

    // Back-to-back non-memory ops
    chk_bus = 1'b0;
    Valid   = 1'b1;
    Ins     = {6'h0D, 26'h0};
    Result  = 32'h0000_0001;
    sbq.push_back('{wb: 32'h0000_0001, adr: 1'b0, berr: 1'b0});
    #1;
    chk("b2b_no_stall", 32'(Stall), 32'(0));
    tick();
    Result = 32'h0000_0002;
    sbq.push_back('{wb: 32'h0000_0002, adr: 1'b0, berr: 1'b0});
    tick();
    Valid = 1'b0;
    tick();
    tick();
    chk("b2b_pending_results", 32'(sbq.size()), 32'(0));
    sbq.delete();

    // Reset while a load is outstanding, then a stray ack
    resp_delay = -1;
    Valid      = 1'b1;
    Ins        = {6'h23, 26'h0};
    Result     = 32'h0000_0020;
    seen       = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (dmem_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_req_raised", 32'(seen), 32'(1));
    RST = 1'b1;
    tick();
    chk("abort_req_dropped", 32'(dmem_req), 32'(0));
    chk("abort_no_outvalid", 32'(OutValid), 32'(0));
    RST        = 1'b0;
    Valid      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_5555;
    ov_seen    = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (OutValid || dmem_req) ov_seen++;
    end
    chk("late_ack_ignored", 32'(ov_seen), 32'(0));
    chk("late_ack_no_stall", 32'(Stall), 32'(0));

    v = '{6'h23, 32'h0000_0024, 32'h0, 32'h1122_3344, 0, 1, 0, 32'h24, 4'hF, 32'h0,
          32'h1122_3344, 0, 0, 2};
    run_vec(v, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
